// File: rtl/apb_pkg.sv
// Shared definitions for the APB command initiator: FSM state encoding,
// default bus widths and the width of the optional timeout counter.
package apb_pkg;

   localparam int APB_DWIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 17;
   localparam int TMO_CNT_WIDTH  = 16;

   // Transfer state encoding (kept as plain constants for legacy tools)
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS wait cycles. tc is raised during the wait cycle whose
// increment would bring the count to LIMIT, so the initiator can abort on
// that same edge and no transfer spends more than LIMIT cycles with PREADY low.
module apb_timeout_counter
   import apb_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [TMO_CNT_WIDTH-1:0] LAST = TMO_CNT_WIDTH'(LIMIT - 1);
   localparam logic [TMO_CNT_WIDTH-1:0] ONE  = TMO_CNT_WIDTH'(1);

   logic [TMO_CNT_WIDTH-1:0] cnt_r;

   // Wait-cycle counter: cleared before each ACCESS phase, counts PREADY-low cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {TMO_CNT_WIDTH{1'b0}};
      end else if (clear) begin
         cnt_r <= {TMO_CNT_WIDTH{1'b0}};
      end else if (enable) begin
         cnt_r <= cnt_r + ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tc = enable && (cnt_r == LAST);

endmodule

// File: rtl/apb_cmd_initiator.sv
// APB3 initiator: turns a valid/ready command into one APB transfer and
// returns read data / error status on a valid/ready response port.
// One transfer outstanding at a time. Define APB_TIMEOUT_EN to abort
// transfers whose slave keeps PREADY low for TIMEOUT_CYCLES cycles.
module apb_cmd_initiator
   import apb_pkg::*;
#(
   parameter int APB_DWIDTH     = APB_DWIDTH_DEF,
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  PCLK,
   input  logic                  PRESETN,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [APB_DWIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [APB_DWIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [APB_DWIDTH-1:0] PWDATA,
   input  logic [APB_DWIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   // Reject unsupported configurations at elaboration time
   generate
      if (!(APB_DWIDTH == 8 || APB_DWIDTH == 16 || APB_DWIDTH == 24 || APB_DWIDTH == 32)) begin : g_bad_dwidth
         $error("apb_cmd_initiator: APB_DWIDTH must be 8, 16, 24 or 32");
      end
      if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
         $error("apb_cmd_initiator: TIMEOUT_CYCLES must be in 1..65535");
      end
   endgenerate

   logic [1:0]            state_r,     state_nxt_s;
   logic                  psel_r,      psel_nxt_s;
   logic                  penable_r,   penable_nxt_s;
   logic                  pwrite_r,    pwrite_nxt_s;
   logic [ADDR_WIDTH-1:0] paddr_r,     paddr_nxt_s;
   logic [APB_DWIDTH-1:0] pwdata_r,    pwdata_nxt_s;
   logic                  rsp_valid_r, rsp_valid_nxt_s;
   logic [APB_DWIDTH-1:0] rsp_rdata_r, rsp_rdata_nxt_s;
   logic                  rsp_err_r,   rsp_err_nxt_s;
   logic                  tmo_hit_s;

`ifdef APB_TIMEOUT_EN
   logic tmo_clear_s;
   logic tmo_en_s;

   assign tmo_clear_s = (state_r == ST_SETUP);
   assign tmo_en_s    = (state_r == ST_ACCESS) && !PREADY;

   apb_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (PCLK),
      .rst_n  (PRESETN),
      .clear  (tmo_clear_s),
      .enable (tmo_en_s),
      .tc     (tmo_hit_s)
   );
`else
   assign tmo_hit_s = 1'b0;
`endif

   // Next-state and next-output decode for the transfer FSM
   always_comb begin
      state_nxt_s     = state_r;
      psel_nxt_s      = psel_r;
      penable_nxt_s   = penable_r;
      pwrite_nxt_s    = pwrite_r;
      paddr_nxt_s     = paddr_r;
      pwdata_nxt_s    = pwdata_r;
      rsp_valid_nxt_s = rsp_valid_r;
      rsp_rdata_nxt_s = rsp_rdata_r;
      rsp_err_nxt_s   = rsp_err_r;

      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_nxt_s  = ST_SETUP;
               psel_nxt_s   = 1'b1;
               pwrite_nxt_s = cmd_write;
               paddr_nxt_s  = cmd_addr;
               pwdata_nxt_s = cmd_wdata;
            end else begin
               state_nxt_s  = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_nxt_s   = ST_ACCESS;
            penable_nxt_s = 1'b1;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               state_nxt_s     = ST_RESP;
               psel_nxt_s      = 1'b0;
               penable_nxt_s   = 1'b0;
               rsp_valid_nxt_s = 1'b1;
               rsp_rdata_nxt_s = pwrite_r ? {APB_DWIDTH{1'b0}} : PRDATA;
               rsp_err_nxt_s   = PSLVERR;
            end else if (tmo_hit_s) begin
               // Slave never answered: abort with an error and no data
               state_nxt_s     = ST_RESP;
               psel_nxt_s      = 1'b0;
               penable_nxt_s   = 1'b0;
               rsp_valid_nxt_s = 1'b1;
               rsp_rdata_nxt_s = {APB_DWIDTH{1'b0}};
               rsp_err_nxt_s   = 1'b1;
            end else begin
               state_nxt_s     = ST_ACCESS;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt_s     = ST_IDLE;
               rsp_valid_nxt_s = 1'b0;
            end else begin
               state_nxt_s     = ST_RESP;
            end
         end
         default: begin
            state_nxt_s     = ST_IDLE;
            psel_nxt_s      = 1'b0;
            penable_nxt_s   = 1'b0;
            rsp_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops the bus and discards any response
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_r     <= ST_IDLE;
         psel_r      <= 1'b0;
         penable_r   <= 1'b0;
         pwrite_r    <= 1'b0;
         paddr_r     <= {ADDR_WIDTH{1'b0}};
         pwdata_r    <= {APB_DWIDTH{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= {APB_DWIDTH{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         psel_r      <= psel_nxt_s;
         penable_r   <= penable_nxt_s;
         pwrite_r    <= pwrite_nxt_s;
         paddr_r     <= paddr_nxt_s;
         pwdata_r    <= pwdata_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
         rsp_rdata_r <= rsp_rdata_nxt_s;
         rsp_err_r   <= rsp_err_nxt_s;
      end
   end

   assign cmd_ready = (state_r == ST_IDLE);
   assign PSEL      = psel_r;
   assign PENABLE   = penable_r;
   assign PWRITE    = pwrite_r;
   assign PADDR     = paddr_r;
   assign PWDATA    = pwdata_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Bench for apb_cmd_initiator. The bench plays the APB SRAM slave itself,
// cycle by cycle, and predicts every response from a memory model and the
// transfer timing rules (SETUP, ACCESS + waits, RESP, back to IDLE).
module tb_apb_cmd_initiator;

   localparam int DW  = 32;
   localparam int AW  = 17;
   localparam int TMO = 4;

   logic          PCLK = 1'b0;
   logic          PRESETN;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA;
   logic          PREADY;
   logic          PSLVERR;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem [logic [AW-1:0]];

   apb_cmd_initiator #(
      .APB_DWIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .PCLK      (PCLK),
      .PRESETN   (PRESETN),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   // Hard stop in case the run ever stalls
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // SRAM content; never-written locations return an address-derived pattern
   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      else return {15'h0000, a} ^ 32'hA5A5_0000;
   endfunction

   // One complete command: starts and ends at a falling edge with the DUT idle.
   task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int waits, input logic serr, input int hold);
      logic          aborted;
      int            acc_cycles;
      logic [DW-1:0] prd;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
      aborted = 1'b0;
`ifdef APB_TIMEOUT_EN
      if (waits >= TMO) aborted = 1'b1;
`endif
      acc_cycles = aborted ? TMO : waits + 1;
      prd        = mem_rd(addr);
      exp_rd     = (wr || aborted) ? 32'h0 : prd;
      exp_err    = aborted ? 1'b1 : serr;

      // IDLE: present the command
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_psel", PSEL, 0);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      rsp_ready = 1'($urandom);
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;

      // SETUP (N+1): command inputs now garbage and must be ignored
      @(negedge PCLK);
      chk("setup_psel", PSEL, 1);
      chk("setup_penable", PENABLE, 0);
      chk("setup_cmd_ready", cmd_ready, 0);
      chk("setup_paddr", PADDR, addr);
      chk("setup_pwrite", PWRITE, wr);
      chk("setup_pwdata", PWDATA, wdata);
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = 17'($urandom); cmd_wdata = $urandom;
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;

      // ACCESS (N+2 ...): slave inserts waits, then completes
      for (int k = 0; k < acc_cycles; k++) begin
         @(negedge PCLK);
         chk("access_psel", PSEL, 1);
         chk("access_penable", PENABLE, 1);
         chk("access_paddr", PADDR, addr);
         chk("access_pwrite", PWRITE, wr);
         chk("access_rsp_valid", rsp_valid, 0);
         if (!aborted && k == acc_cycles - 1) begin
            PREADY = 1'b1; PSLVERR = serr; PRDATA = prd;
         end else begin
            PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
         end
      end

      // RESP: response presented, bus released
      @(negedge PCLK);
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      chk("resp_valid", rsp_valid, 1);
      chk("resp_psel", PSEL, 0);
      chk("resp_penable", PENABLE, 0);
      chk("resp_rdata", rsp_rdata, exp_rd);
      chk("resp_err", rsp_err, exp_err);
      rsp_ready = (hold == 0);
      for (int h = 1; h <= hold; h++) begin
         @(negedge PCLK);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_rdata", rsp_rdata, exp_rd);
         chk("hold_err", rsp_err, exp_err);
         chk("hold_cmd_ready", cmd_ready, 0);
         chk("hold_psel", PSEL, 0);
         rsp_ready = (h == hold);
      end

      // Back in IDLE one cycle after the response handshake
      @(negedge PCLK);
      chk("done_rsp_valid", rsp_valid, 0);
      chk("done_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b0;
      rsp_ready = 1'($urandom);
      if (wr && !exp_err) mem[addr] = wdata;
   endtask

   logic [AW-1:0] addr_pool [4];
   logic          r_wr;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   int            r_waits;
   logic          r_err;
   int            r_hold;

   initial begin
      addr_pool[0] = 17'h00010; addr_pool[1] = 17'h00100;
      addr_pool[2] = 17'h0ABC4; addr_pool[3] = 17'h1FFFC;
      PRESETN = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 17'h0; cmd_wdata = 32'h0;
      rsp_ready = 1'b0; PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;

      // Reset state
      repeat (2) @(negedge PCLK);
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      PRESETN = 1'b1;
      @(negedge PCLK);

      // Write then read back, zero waits, back-to-back
      xfer(1'b1, 17'h00010, 32'hDEADBEEF, 0, 1'b0, 0);
      xfer(1'b0, 17'h00010, 32'h0BAD_F00D, 0, 1'b0, 0);

      // Three wait states
      mem[17'h00100] = 32'h12345678;
      xfer(1'b0, 17'h00100, 32'h0, 3, 1'b0, 0);

      // Slave error on a write, then a clean read of the same location
      xfer(1'b1, 17'h1FFFC, 32'hCAFE_0001, 0, 1'b1, 0);
      xfer(1'b0, 17'h1FFFC, 32'h0, 0, 1'b0, 0);

      // Response backpressure
      xfer(1'b0, 17'h00010, 32'h0, 1, 1'b0, 5);

      // Randomized traffic
      for (int i = 0; i < 30; i++) begin
         r_wr    = 1'($urandom_range(0, 1));
         r_addr  = addr_pool[$urandom_range(0, 3)];
         r_data  = $urandom;
         r_waits = $urandom_range(0, 6);
         r_err   = ($urandom_range(0, 7) == 0);
         r_hold  = $urandom_range(0, 3);
         xfer(r_wr, r_addr, r_data, r_waits, r_err, r_hold);
      end

      // Reset in the middle of an ACCESS wait state
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 17'h0ABC4; cmd_wdata = 32'h0;
      PREADY = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      chk("pre_rst_penable", PENABLE, 1);
      PRESETN = 1'b0;
      #1;
      chk("mid_rst_psel", PSEL, 0);
      chk("mid_rst_penable", PENABLE, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_paddr", PADDR, 0);
      @(negedge PCLK);
      PRESETN = 1'b1;
      @(negedge PCLK);
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("post_rst_psel", PSEL, 0);

      // Slave never raises PREADY for a long stretch (aborts when timeout is built in)
      xfer(1'b0, 17'h00100, 32'h0, 40, 1'b0, 0);
      xfer(1'b1, 17'h0ABC4, 32'h5A5A_A5A5, 0, 1'b0, 0);
      xfer(1'b0, 17'h0ABC4, 32'h0, 2, 1'b0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
